// File: rtl/tff_mod_counter.sv
// Modulo counter built from a bank of T-type cells: hold, up, down and raw toggle-mask modes,
// with parallel load, a wrap pulse and an illegal-value pulse.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             c,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tmask,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap,
  output logic             err
);

  generate
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
      $error("tff_mod_counter: MODULUS must lie in 2..2**WIDTH and WIDTH must be >= 1");
    end
  endgenerate

  // One extra bit so MODULUS == 2**WIDTH is representable in the legality compares.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_reg;
  logic             wrap_reg;
  logic             err_reg;

  logic [WIDTH-1:0] t_next;
  logic             wrap_next;
  logic             err_next;
  logic [WIDTH-1:0] toggled;
  logic [WIDTH-1:0] load_val;
  logic             load_err;

  // Toggle vector: each t bit marks a cell that must flip to reach the wanted next value.
  always_comb begin
    t_next    = '0;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    toggled   = q_reg ^ tmask;
    if (en) begin
      case (mode_t'(mode))
        MODE_UP: begin
          if (q_reg == MAX_Q) begin
            t_next    = q_reg;
            wrap_next = 1'b1;
          end else begin
            t_next = q_reg ^ (q_reg + ONE);
          end
        end
        MODE_DOWN: begin
          if (q_reg == '0) begin
            t_next    = MAX_Q;
            wrap_next = 1'b1;
          end else begin
            t_next = q_reg ^ (q_reg - ONE);
          end
        end
        MODE_TOGGLE: begin
          if ({1'b0, toggled} < MOD_W) begin
            t_next = tmask;
          end else begin
            t_next   = q_reg;
            err_next = 1'b1;
          end
        end
        default: t_next = '0;
      endcase
    end
  end

  always_comb begin
    load_err = !({1'b0, d} < MOD_W);
    load_val = load_err ? '0 : d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tcell
      always_ff @(posedge c) begin
        if (rs) begin
          q_reg[gi] <= 1'b0;
        end else if (ld) begin
          q_reg[gi] <= load_val[gi];
        end else begin
          q_reg[gi] <= q_reg[gi] ^ t_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge c) begin
    if (rs) begin
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (ld) begin
      wrap_reg <= 1'b0;
      err_reg  <= load_err;
    end else begin
      wrap_reg <= wrap_next;
      err_reg  <= err_next;
    end
  end

  assign q    = q_reg;
  assign qb   = ~q_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter (WIDTH=4, MODULUS=10): directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_tff_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         c = 1'b0;
  logic         rs = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] tmask = '0;
  logic         ld = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         wrap;
  logic         err;

  int total = 0;
  int bad = 0;
  int txn = 0;

  // Reference state
  int mq = 0;
  bit mwrap = 0;
  bit merr = 0;

  tff_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .c(c), .rs(rs), .en(en), .mode(mode), .tmask(tmask),
    .ld(ld), .d(d), .q(q), .qb(qb), .wrap(wrap), .err(err)
  );

  always #5 c = ~c;

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    int r;
    mwrap = 0;
    merr  = 0;
    if (rs) begin
      mq = 0;
    end else if (ld) begin
      if (int'(d) < M) mq = int'(d);
      else begin
        mq = 0;
        merr = 1;
      end
    end else if (en && mode == 2'b01) begin
      mwrap = (mq + 1 == M);
      mq = (mq + 1) % M;
    end else if (en && mode == 2'b10) begin
      mwrap = (mq == 0);
      mq = (mq + M - 1) % M;
    end else if (en && mode == 2'b11) begin
      r = mq ^ int'(tmask);
      if (r < M) mq = r;
      else begin
        mq = 0;
        merr = 1;
      end
    end
    @(posedge c);
    #1;
    txn++;
    $display("txn %0d: rs=%0b ld=%0b d=%0d en=%0b mode=%0d tmask=%0h -> q=%0d wrap=%0b err=%0b",
             txn, rs, ld, d, en, mode, tmask, q, wrap, err);
  endtask

  task automatic test_reset();
    rs = 1; en = 1; mode = 2'b01; ld = 0;
    tick();
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_q: got %0d expected 0", q); end
    total++; if (qb !== 4'hF) begin bad++; $display("FAIL reset_qb: got %0h expected f", qb); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", err); end
  endtask

  task automatic test_up();
    int exp_q;
    rs = 0; en = 1; mode = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_q = i % 10;
      total++;
      if (q !== W'(exp_q)) begin bad++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, exp_q); end
      total++;
      if (wrap !== (i == 10)) begin bad++; $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap, i == 10); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL up_err[%0d]: got %0b expected 0", i, err); end
    end
  endtask

  task automatic test_down();
    int exp_seq[3] = '{9, 8, 7};
    ld = 1; d = 0;
    tick();
    ld = 0; en = 1; mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q !== W'(exp_seq[i])) begin bad++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, exp_seq[i]); end
      total++;
      if (wrap !== (i == 0)) begin bad++; $display("FAIL down_wrap[%0d]: got %0b expected %0b", i, wrap, i == 0); end
    end
  endtask

  task automatic test_load();
    ld = 1; d = 7; en = 1; mode = 2'b01;
    tick();
    total++; if (q !== 4'd7) begin bad++; $display("FAIL load_q: got %0d expected 7", q); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err: got %0b expected 0", err); end
    d = 12;
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL load_bad_q: got %0d expected 0", q); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL load_bad_err: got %0b expected 1", err); end
    ld = 0; en = 0;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err_clear: got %0b expected 0", err); end
  endtask

  task automatic test_toggle();
    ld = 1; d = 5;
    tick();
    ld = 0; en = 1; mode = 2'b11; tmask = 4'b0011;
    tick();
    total++; if (q !== 4'd6) begin bad++; $display("FAIL toggle_q: got %0d expected 6", q); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL toggle_err: got %0b expected 0", err); end
    tmask = 4'b1000;
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL toggle_bad_q: got %0d expected 0", q); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL toggle_bad_err: got %0b expected 1", err); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL toggle_wrap: got %0b expected 0", wrap); end
  endtask

  task automatic test_reset_priority();
    ld = 1; d = 8; en = 0;
    tick();
    ld = 1; d = 3; rs = 1; en = 1; mode = 2'b01;
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL rs_over_ld_q: got %0d expected 0", q); end
    rs = 0; ld = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (q !== 4'd0) begin bad++; $display("FAIL hold_q[%0d]: got %0d expected 0", i, q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL hold_wrap[%0d]: got %0b expected 0", i, wrap); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs    = ($urandom_range(0, 39) == 0);
      ld    = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 4) != 0);
      mode  = 2'($urandom_range(0, 3));
      tmask = W'($urandom_range(0, 15));
      d     = W'($urandom_range(0, 15));
      tick();
      total++;
      if (q !== W'(mq) || qb !== ~W'(mq) || wrap !== mwrap || err !== merr) begin
        bad++;
        $display("FAIL random[%0d]: got q=%0d qb=%0h wrap=%0b err=%0b expected q=%0d qb=%0h wrap=%0b err=%0b",
                 i, q, qb, wrap, err, mq, ~W'(mq), mwrap, merr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_load();
    test_toggle();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
